fb_scan_reader: RTL and testbench

Avalon-MM read master that scans the on-chip frame-buffer memory (38400 × 32-bit words, 320×240 pixels at 16 bpp) from word 0 to the last word once per `start` pulse. It splits each word into two 16-bit pixels and presents them on a valid/ready stream toward the video output path. It is the initiator for the on-chip memory's s2 slave port, which has fixed read latency 1 and no waitrequest. Reads are throttled by a small word FIFO so that stream backpressure never loses data.

---
 rtl/fb_scan_reader.sv | 175 +++++++++++++++++
 tb/tb_fb_scan_reader.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_scan_reader.sv
// fb_scan_reader: Avalon-MM read master that scans the frame buffer once per
// start pulse and streams each 32-bit word as two 16-bit pixels (low half
// first) on a valid/ready interface. Reads are credit-limited by a small
// show-ahead word FIFO so stream backpressure never drops data.
module fb_scan_reader #(
  parameter int unsigned NUM_WORDS  = 38400,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_chipselect,
  output logic              m_read,
  output logic              m_write,
  output logic [3:0]        m_byteenable,
  output logic              m_clken,
  input  logic [31:0]       m_readdata,
  output logic [15:0]       st_data,
  output logic              st_valid,
  input  logic              st_ready,
  output logic              st_sop,
  output logic              st_eop
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t                r_state;
  logic [ADDR_W-1:0]     r_addr;
  logic                  r_inflight;
  logic                  r_inflight_last;
  logic                  r_hsel;
  logic                  r_first;
  logic                  r_done;
  logic [31:0]           r_mem [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] r_tag;
  logic [PW-1:0]         r_wptr;
  logic [PW-1:0]         r_rptr;
  logic [CW-1:0]         r_count;

  logic [CW:0]           w_credit;
  logic                  w_rd;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_hs;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_eop;
  logic [31:0]           w_head;

  // A read is issued only when the FIFO can hold it plus the one in flight.
  assign w_credit = (CW+1)'(r_count) + (CW+1)'(r_inflight);
  assign w_rd     = (r_state == S_RUN) && (w_credit < (CW+1)'(FIFO_DEPTH));
  assign w_push   = r_inflight;
  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == CW'(FIFO_DEPTH));
  assign w_hs     = !w_empty && st_ready;
  assign w_pop    = w_hs && r_hsel;
  assign w_head   = r_mem[r_rptr];
  assign w_eop    = !w_empty && r_tag[r_rptr] && r_hsel;

  assign busy         = (r_state != S_IDLE);
  assign done         = r_done;
  assign m_address    = r_addr;
  assign m_read       = w_rd;
  assign m_chipselect = w_rd;
  assign m_write      = 1'b0;
  assign m_byteenable = 4'hF;
  assign m_clken      = 1'b1;

  // Empty FIFO forces zero data so outputs never expose unreset storage.
  assign st_valid = !w_empty;
  assign st_data  = w_empty ? '0 : (r_hsel ? w_head[31:16] : w_head[15:0]);
  assign st_sop   = !w_empty && r_first && !r_hsel;
  assign st_eop   = w_eop;

  // Frame control: address counter, first-pixel flag and done pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_first <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_hs) begin
        r_first <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_RUN;
            r_addr  <= '0;
            r_first <= 1'b1;
          end
        end
        S_RUN: begin
          if (w_rd) begin
            r_addr <= r_addr + ADDR_W'(1);
            if (r_addr == LAST_ADDR) begin
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (w_hs && w_eop) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Read-latency tracking: data returns one cycle after an accepted read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
    end else begin
      r_inflight      <= w_rd;
      r_inflight_last <= w_rd && (r_addr == LAST_ADDR);
    end
  end

  // FIFO pointers, occupancy and half-word select.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_hsel  <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CW'(1);
      end
      if (w_hs) begin
        r_hsel <= !r_hsel;
      end
    end
  end

  // FIFO storage; the tag marks the frame's final word for end-of-packet.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= m_readdata;
      r_tag[r_wptr] <= r_inflight_last;
    end
  end

  // The credit rule guarantees a returning word always has a free slot.
  a_no_push_when_full: assert property (
    @(posedge clk) disable iff (!reset_n) !(w_push && w_full));

endmodule

// File: tb/tb_fb_scan_reader.sv
// Testbench for fb_scan_reader: memory model, stimulus and a scoreboard
// monitor that checks every pixel handshake and the done pulse.
module tb_fb_scan_reader;

  localparam int unsigned NW   = 600;
  localparam int unsigned NPIX = 2 * NW;

  typedef struct packed {
    logic [15:0] d;
    logic        sop;
    logic        eop;
  } pix_t;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        busy;
  logic        done;
  logic [15:0] m_address;
  logic        m_chipselect;
  logic        m_read;
  logic        m_write;
  logic [3:0]  m_byteenable;
  logic        m_clken;
  logic [31:0] m_readdata;
  logic [15:0] st_data;
  logic        st_valid;
  logic        st_ready;
  logic        st_sop;
  logic        st_eop;

  int n_checks = 0;
  int n_errors = 0;
  int rdy_mode = 0;
  int pix_total = 0;
  int rd_total = 0;
  int rd_last = 0;
  pix_t q[$];

  fb_scan_reader #(
    .NUM_WORDS(NW),
    .ADDR_W(16),
    .FIFO_DEPTH(8)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .busy(busy),
    .done(done),
    .m_address(m_address),
    .m_chipselect(m_chipselect),
    .m_read(m_read),
    .m_write(m_write),
    .m_byteenable(m_byteenable),
    .m_clken(m_clken),
    .m_readdata(m_readdata),
    .st_data(st_data),
    .st_valid(st_valid),
    .st_ready(st_ready),
    .st_sop(st_sop),
    .st_eop(st_eop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [15:0] a);
    int unsigned p;
    p = 2 * int'(a);
    return {16'(p + 1), 16'(p)};
  endfunction

  // Memory slave with read latency 1.
  always @(posedge clk) begin
    m_readdata <= m_read ? word_at(m_address) : 32'hDEAD_BEEF;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Sink ready pattern: 0 = always ready, 1 = random, other = stalled.
  initial begin
    st_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       st_ready = 1'b1;
        1:       st_ready = 1'($urandom_range(0, 1));
        default: st_ready = 1'b0;
      endcase
    end
  end

  // Read request logger.
  always @(negedge clk) begin
    if (m_read) begin
      rd_total++;
      rd_last = int'(m_address);
    end
  end

  // Scoreboard monitor.
  logic        done_pend = 1'b0;
  logic        prev_stall = 1'b0;
  logic [17:0] ps_val = '0;
  always @(negedge clk) begin
    pix_t e;
    if (!reset_n) begin
      done_pend  = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (done || done_pend) check("done_pulse", 32'(done), 32'(done_pend));
      if (prev_stall) check("stall_hold", {13'b0, st_valid, st_sop, st_eop, st_data}, {13'b0, 1'b1, ps_val});
      done_pend = 1'b0;
      if (st_valid && st_ready) begin
        pix_total++;
        if (q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_pixel: got 0x%0h expected none at %0t", st_data, $time);
        end else begin
          e = q.pop_front();
          check("pixel", {14'b0, st_sop, st_eop, st_data}, {14'b0, e.sop, e.eop, e.d});
        end
        if (st_eop) done_pend = 1'b1;
      end
      prev_stall = st_valid && !st_ready;
      ps_val     = {st_sop, st_eop, st_data};
    end
  end

  task automatic start_frame();
    for (int p = 0; p < int'(NPIX); p++) begin
      q.push_back('{d: 16'(p), sop: (p == 0), eop: (p == int'(NPIX) - 1)});
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < limit);
    if (!done) check("done_timeout", 32'(done), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int bad;
    int base;
    reset_n = 1'b0;
    start   = 1'b0;

    // Reset and idle.
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_read", {30'b0, m_read, m_chipselect}, 0);
    check("rst_stream", {29'b0, st_valid, st_sop, st_eop}, 0);
    check("rst_addr", 32'(m_address), 0);
    check("rst_data", 32'(st_data), 0);
    check("const_ctl", {26'b0, m_write, m_byteenable, m_clken}, {26'b0, 1'b0, 4'hF, 1'b1});
    reset_n = 1'b1;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (m_read || busy || st_valid || done || st_data != 16'h0) bad++;
    end
    check("idle_quiet", 32'(bad), 0);

    // Full frame, always ready; a start while busy must be ignored.
    rdy_mode = 0;
    @(negedge clk);
    base = pix_total;
    start_frame();
    check("first_read", {14'b0, m_read, m_chipselect, m_address}, {14'b0, 1'b1, 1'b1, 16'h0});
    check("busy_after_start", 32'(busy), 1);
    check("valid_e0", 32'(st_valid), 0);
    @(negedge clk);
    check("valid_e1", 32'(st_valid), 0);
    @(negedge clk);
    check("valid_e2", {30'b0, st_valid, st_sop}, 32'b11);
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(4 * NPIX, n);
    check("frame_cycles", 32'(6 + n), 32'(NPIX + 2));
    check("busy_at_done", 32'(busy), 0);
    check("frame_pixels", 32'(pix_total - base), 32'(NPIX));
    check("queue_empty_a", 32'(q.size()), 0);

    // Backpressure from the first valid.
    @(negedge clk);
    rdy_mode = 2;
    base = rd_total;
    start_frame();
    repeat (30) @(negedge clk);
    check("bp_reads", 32'(rd_total - base), 8);
    check("bp_last_addr", 32'(rd_last), 7);
    check("bp_stalled", {30'b0, m_read, st_valid}, 32'b01);
    rdy_mode = 0;
    n = 0;
    while (!m_read && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("bp_resume", {15'b0, m_read, m_address}, {15'b0, 1'b1, 16'd8});
    wait_done(4 * NPIX, n);
    check("queue_empty_b", 32'(q.size()), 0);

    // Start in the done cycle, random ready for the whole frame.
    rdy_mode = 1;
    start_frame();
    check("restart_read", {15'b0, m_read, m_address}, {15'b0, 1'b1, 16'h0});
    wait_done(8 * NPIX, n);
    check("queue_empty_c", 32'(q.size()), 0);

    // Reset mid-frame, then a fresh frame.
    rdy_mode = 0;
    @(negedge clk);
    base = pix_total;
    start_frame();
    n = 0;
    while (pix_total - base < 100 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("mid_progress", 32'(pix_total - base >= 100), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_ctl", {29'b0, busy, done, m_read}, 0);
    check("async_rst_stream", {13'b0, st_valid, st_sop, st_eop, st_data}, 0);
    check("async_rst_addr", 32'(m_address), 0);
    q.delete();
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) bad++;
    end
    reset_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (done || busy) bad++;
    end
    check("no_done_after_rst", 32'(bad), 0);
    start_frame();
    wait_done(4 * NPIX, n);
    check("queue_empty_d", 32'(q.size()), 0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
